// File: rtl/mul_rs_if.sv
// Dispatch, CDB snoop and CDB request/grant bundle for the multiply reservation station.
// The slave side is the station; the master side is dispatch plus the CDB arbiter.
interface mul_rs_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              in_rs_enable;
  logic [5:0]        in_operator_type;
  logic [DATA_W-1:0] in_val_1;
  logic [DATA_W-1:0] in_val_2;
  logic [TAG_W-1:0]  in_tag_1;
  logic [TAG_W-1:0]  in_tag_2;
  logic              in_CDB_broadcast;
  logic [TAG_W-1:0]  in_CDB_tag;
  logic [DATA_W-1:0] in_CDB_val;
  logic              in_CDB_grant;
  logic              out_rs_full;
  logic [TAG_W-1:0]  out_rs_tag;
  logic              out_CDB_request;
  logic [TAG_W-1:0]  out_CDB_tag;
  logic [DATA_W-1:0] out_CDB_val;
  logic [DATA_W-1:0] out_Y_val;
  logic [3:0]        out_ICC_flags;
  logic              out_ICC_valid;

  modport slave (
    input  in_rs_enable, in_operator_type, in_val_1, in_val_2, in_tag_1, in_tag_2,
    input  in_CDB_broadcast, in_CDB_tag, in_CDB_val, in_CDB_grant,
    output out_rs_full, out_rs_tag, out_CDB_request, out_CDB_tag, out_CDB_val,
    output out_Y_val, out_ICC_flags, out_ICC_valid
  );

  modport master (
    output in_rs_enable, in_operator_type, in_val_1, in_val_2, in_tag_1, in_tag_2,
    output in_CDB_broadcast, in_CDB_tag, in_CDB_val, in_CDB_grant,
    input  out_rs_full, out_rs_tag, out_CDB_request, out_CDB_tag, out_CDB_val,
    input  out_Y_val, out_ICC_flags, out_ICC_valid
  );
endinterface

// File: rtl/mul_rs_multi.sv
// Multi-entry reservation station feeding a MUL_LAT-stage pipelined 32x32->64 multiplier,
// with CDB operand snooping and a held result register arbitrating for the CDB.
module mul_rs_entry #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic [5:0]        d_op,
  input  logic [DATA_W-1:0] d_val1,
  input  logic [DATA_W-1:0] d_val2,
  input  logic [TAG_W-1:0]  d_tag1,
  input  logic [TAG_W-1:0]  d_tag2,
  input  logic              cdb_vld,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  input  logic              issue,
  input  logic              free,
  output logic              busy,
  output logic              ready,
  output logic [5:0]        op,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2
);
  localparam logic [TAG_W-1:0] INV = {TAG_W{1'b1}};

  logic             issued;
  logic [TAG_W-1:0] tag1, tag2;
  logic             hit1, hit2;

  assign hit1  = cdb_vld && (tag1 != INV) && (tag1 == cdb_tag);
  assign hit2  = cdb_vld && (tag2 != INV) && (tag2 == cdb_tag);
  assign ready = busy && !issued && (tag1 == INV) && (tag2 == INV);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      issued <= 1'b0;
      op     <= '0;
      val1   <= '0;
      val2   <= '0;
      tag1   <= INV;
      tag2   <= INV;
    end else if (alloc) begin
      busy   <= 1'b1;
      issued <= 1'b0;
      op     <= d_op;
      val1   <= d_val1;
      val2   <= d_val2;
      tag1   <= d_tag1;
      tag2   <= d_tag2;
    end else begin
      if (free) begin
        busy   <= 1'b0;
        issued <= 1'b0;
      end
      if (issue) issued <= 1'b1;
      if (busy && hit1) begin
        val1 <= cdb_val;
        tag1 <= INV;
      end
      if (busy && hit2) begin
        val2 <= cdb_val;
        tag2 <= INV;
      end
    end
  end
endmodule

module mul_rs_multi #(
  parameter int NUM_ENTRIES = 4,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 5,
  parameter int RS_ID_BASE  = 8,
  parameter int MUL_LAT     = 3
) (
  input  logic   clk,
  input  logic   reset,
  mul_rs_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int STAGES = MUL_LAT - 1;
  localparam logic [TAG_W-1:0] INV = {TAG_W{1'b1}};

  typedef struct packed {
    logic [2*DATA_W-1:0] prod;
    logic [IDX_W-1:0]    idx;
    logic                ccv;
  } stage_t;

  logic [NUM_ENTRIES-1:0]             busy, ready, alloc_vec, issue_vec, free_vec;
  logic [NUM_ENTRIES-1:0][5:0]        e_op;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0] e_val1, e_val2;

  logic [IDX_W-1:0]  alloc_idx, iss_idx;
  logic              any_ready, full, do_alloc, adv, issue_go;
  logic [DATA_W-1:0] disp_val1, disp_val2;
  logic [TAG_W-1:0]  disp_tag1, disp_tag2;

  // Lowest-index free entry for allocation, lowest-index ready entry for issue.
  always_comb begin
    alloc_idx = '0;
    iss_idx   = '0;
    any_ready = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_idx = IDX_W'(i);
      if (ready[i]) begin
        iss_idx   = IDX_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  logic              res_vld, res_ccv;
  logic [IDX_W-1:0]  res_idx;
  logic [DATA_W-1:0] res_lo, res_hi;
  logic [3:0]        res_icc;

  assign full      = &busy;
  assign do_alloc  = bus.in_rs_enable && !full;
  assign alloc_vec = do_alloc ? (NUM_ENTRIES'(1) << alloc_idx) : '0;
  assign adv       = !res_vld || bus.in_CDB_grant;
  assign issue_go  = adv && any_ready;
  assign issue_vec = issue_go ? (NUM_ENTRIES'(1) << iss_idx) : '0;
  assign free_vec  = (res_vld && bus.in_CDB_grant) ? (NUM_ENTRIES'(1) << res_idx) : '0;

  // An operand whose producer is on the CDB in the dispatch cycle is captured directly.
  always_comb begin
    disp_val1 = bus.in_val_1;
    disp_tag1 = bus.in_tag_1;
    disp_val2 = bus.in_val_2;
    disp_tag2 = bus.in_tag_2;
    if (bus.in_CDB_broadcast && bus.in_tag_1 != INV && bus.in_tag_1 == bus.in_CDB_tag) begin
      disp_val1 = bus.in_CDB_val;
      disp_tag1 = INV;
    end
    if (bus.in_CDB_broadcast && bus.in_tag_2 != INV && bus.in_tag_2 == bus.in_CDB_tag) begin
      disp_val2 = bus.in_CDB_val;
      disp_tag2 = INV;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_ENTRIES; g++) begin : g_ent
      mul_rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_ent (
        .clk     (clk),
        .reset   (reset),
        .alloc   (alloc_vec[g]),
        .d_op    (bus.in_operator_type),
        .d_val1  (disp_val1),
        .d_val2  (disp_val2),
        .d_tag1  (disp_tag1),
        .d_tag2  (disp_tag2),
        .cdb_vld (bus.in_CDB_broadcast),
        .cdb_tag (bus.in_CDB_tag),
        .cdb_val (bus.in_CDB_val),
        .issue   (issue_vec[g]),
        .free    (free_vec[g]),
        .busy    (busy[g]),
        .ready   (ready[g]),
        .op      (e_op[g]),
        .val1    (e_val1[g]),
        .val2    (e_val2[g])
      );
    end
  endgenerate

  // Unknown op3 values fall through as unsigned with no condition codes.
  logic [5:0]          iss_op;
  logic                iss_signed, iss_ccv;
  logic [2*DATA_W-1:0] ext_a, ext_b, iss_prod;

  assign iss_op     = e_op[iss_idx];
  assign iss_signed = (iss_op == 6'h0B) || (iss_op == 6'h1B);
  assign iss_ccv    = (iss_op == 6'h1A) || (iss_op == 6'h1B);
  assign ext_a      = {{DATA_W{iss_signed & e_val1[iss_idx][DATA_W-1]}}, e_val1[iss_idx]};
  assign ext_b      = {{DATA_W{iss_signed & e_val2[iss_idx][DATA_W-1]}}, e_val2[iss_idx]};
  assign iss_prod   = ext_a * ext_b;

  logic [STAGES:0] vld_pipe;
  stage_t          pipe [STAGES:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i <= STAGES; i++) pipe[i] <= '0;
    end else if (adv) begin
      vld_pipe[0] <= issue_go;
      pipe[0]     <= '{prod: iss_prod, idx: iss_idx, ccv: iss_ccv};
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pipe[i]     <= pipe[i-1];
      end
    end
  end

  logic [DATA_W-1:0] fin_lo;
  assign fin_lo = pipe[STAGES].prod[DATA_W-1:0];

  // Result register: held until granted, reloaded from the last stage on the grant edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_vld <= 1'b0;
      res_idx <= '0;
      res_lo  <= '0;
      res_hi  <= '0;
      res_icc <= '0;
      res_ccv <= 1'b0;
    end else if (adv) begin
      res_vld <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        res_idx <= pipe[STAGES].idx;
        res_lo  <= fin_lo;
        res_hi  <= pipe[STAGES].prod[2*DATA_W-1:DATA_W];
        res_icc <= {fin_lo[DATA_W-1], (fin_lo == '0), 2'b00};
        res_ccv <= pipe[STAGES].ccv;
      end else begin
        res_idx <= '0;
        res_lo  <= '0;
        res_hi  <= '0;
        res_icc <= '0;
        res_ccv <= 1'b0;
      end
    end
  end

  assign bus.out_rs_full     = full;
  assign bus.out_rs_tag      = TAG_W'(RS_ID_BASE) + TAG_W'(alloc_idx);
  assign bus.out_CDB_request = res_vld;
  assign bus.out_CDB_tag     = res_vld ? (TAG_W'(RS_ID_BASE) + TAG_W'(res_idx)) : '0;
  assign bus.out_CDB_val     = res_lo;
  assign bus.out_Y_val       = res_hi;
  assign bus.out_ICC_flags   = res_icc;
  assign bus.out_ICC_valid   = res_ccv;
endmodule

// File: tb/tb_mul_rs_multi.sv
// Bench for mul_rs_multi: directed scenarios plus a randomized run scored against
// a tag-indexed model of expected products and station occupancy.
module tb_mul_rs_multi;
  localparam int NE = 4, DW = 32, TW = 5, BASE = 8, LAT = 3;
  localparam logic [TW-1:0] INV = 5'h1F;

  logic clk, reset;
  mul_rs_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  mul_rs_multi #(.NUM_ENTRIES(NE), .DATA_W(DW), .TAG_W(TW), .RS_ID_BASE(BASE), .MUL_LAT(LAT))
    dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  function automatic void ref_mul(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic [3:0] icc, output logic ccv);
    logic [63:0] p;
    if (op == 6'h0B || op == 6'h1B) p = longint'($signed(a)) * longint'($signed(b));
    else                            p = {32'h0, a} * {32'h0, b};
    lo  = p[31:0];
    hi  = p[63:32];
    icc = {lo[31], (lo == 32'h0), 2'b00};
    ccv = (op == 6'h1A || op == 6'h1B);
  endfunction

  task automatic idle_inputs();
    bus.in_rs_enable = 0; bus.in_operator_type = 0;
    bus.in_val_1 = 0; bus.in_val_2 = 0; bus.in_tag_1 = INV; bus.in_tag_2 = INV;
    bus.in_CDB_broadcast = 0; bus.in_CDB_tag = 0; bus.in_CDB_val = 0; bus.in_CDB_grant = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] v1, input logic [TW-1:0] t1,
                          input logic [31:0] v2, input logic [TW-1:0] t2);
    bus.in_rs_enable = 1; bus.in_operator_type = op;
    bus.in_val_1 = v1; bus.in_tag_1 = t1; bus.in_val_2 = v2; bus.in_tag_2 = t2;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.out_CDB_request) begin ok = 1; return; end
      @(negedge clk);
    end
    ok = bus.out_CDB_request;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.out_CDB_request !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.out_CDB_request); end
    n_vec++; if (bus.out_rs_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.out_rs_full); end
    n_vec++; if (bus.out_rs_tag !== 5'd8) begin n_err++; $display("FAIL reset_rs_tag: got %0d want 8", bus.out_rs_tag); end
    n_vec++; if ({bus.out_CDB_tag, bus.out_CDB_val, bus.out_Y_val, bus.out_ICC_flags, bus.out_ICC_valid} !== '0) begin
      n_err++; $display("FAIL reset_outs: got tag %h val %h y %h icc %b v %b want all 0",
                        bus.out_CDB_tag, bus.out_CDB_val, bus.out_Y_val, bus.out_ICC_flags, bus.out_ICC_valid);
    end
  endtask

  task automatic test_umul_latency();
    do_reset();
    dispatch(6'h0A, 32'd2, INV, 32'd3, INV);
    @(negedge clk);
    bus.in_rs_enable = 0;
    for (int i = 0; i < LAT; i++) begin
      n_vec++; if (bus.out_CDB_request !== 1'b0) begin n_err++; $display("FAIL umul_early_req: cycle %0d got 1 want 0", i); end
      @(negedge clk);
    end
    n_vec++; if (bus.out_CDB_request !== 1'b0) begin n_err++; $display("FAIL umul_early_req_last: got 1 want 0"); end
    @(negedge clk);
    n_vec++; if (bus.out_CDB_request !== 1'b1) begin n_err++; $display("FAIL umul_req: got %b want 1", bus.out_CDB_request); end
    n_vec++; if ({bus.out_CDB_tag, bus.out_CDB_val, bus.out_Y_val, bus.out_ICC_flags, bus.out_ICC_valid} !==
                 {5'd8, 32'd6, 32'd0, 4'b0000, 1'b0}) begin
      n_err++; $display("FAIL umul_result: got tag %0d val %h y %h icc %b v %b want 8 6 0 0000 0",
                        bus.out_CDB_tag, bus.out_CDB_val, bus.out_Y_val, bus.out_ICC_flags, bus.out_ICC_valid);
    end
    bus.in_CDB_grant = 1;
    @(negedge clk);
    bus.in_CDB_grant = 0;
    n_vec++; if (bus.out_CDB_request !== 1'b0) begin n_err++; $display("FAIL umul_req_drop: got 1 want 0"); end
  endtask

  task automatic test_cdb_wakeup();
    bit ok;
    do_reset();
    dispatch(6'h0A, 32'd4, INV, 32'hDEAD, 5'd3);
    @(negedge clk);
    bus.in_rs_enable = 0;
    @(negedge clk);
    bus.in_CDB_broadcast = 1; bus.in_CDB_tag = 5'd3; bus.in_CDB_val = 32'd1;
    @(negedge clk);
    bus.in_CDB_broadcast = 0;
    wait_req(20, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wakeup_timeout: no request within budget"); end
    n_vec++; if (bus.out_CDB_val !== 32'd4 || bus.out_CDB_tag !== 5'd8) begin
      n_err++; $display("FAIL wakeup_result: got tag %0d val %h want 8 4", bus.out_CDB_tag, bus.out_CDB_val);
    end
    bus.in_CDB_grant = 1;
    @(negedge clk);
    bus.in_CDB_grant = 0;
    n_vec++; if (bus.out_rs_tag !== 5'd8 || bus.out_rs_full !== 1'b0 || bus.out_CDB_request !== 1'b0) begin
      n_err++; $display("FAIL wakeup_free: got rs_tag %0d full %b req %b want 8 0 0",
                        bus.out_rs_tag, bus.out_rs_full, bus.out_CDB_request);
    end
  endtask

  task automatic test_smulcc();
    bit ok;
    do_reset();
    dispatch(6'h1B, 32'hFFFF_FFFE, INV, 32'd3, INV);
    @(negedge clk);
    bus.in_rs_enable = 0;
    wait_req(20, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL smulcc_timeout: no request within budget"); end
    n_vec++; if ({bus.out_CDB_val, bus.out_Y_val, bus.out_ICC_flags, bus.out_ICC_valid} !==
                 {32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000, 1'b1}) begin
      n_err++; $display("FAIL smulcc_result: got val %h y %h icc %b v %b want fffffffa ffffffff 1000 1",
                        bus.out_CDB_val, bus.out_Y_val, bus.out_ICC_flags, bus.out_ICC_valid);
    end
    bus.in_CDB_grant = 1;
    @(negedge clk);
    bus.in_CDB_grant = 0;
  endtask

  task automatic test_full_and_freeze();
    bit ok;
    do_reset();
    for (int k = 0; k < NE; k++) begin
      dispatch(6'h0A, 32'(k + 1), INV, 32'h0, 5'd3);
      @(negedge clk);
    end
    n_vec++; if (bus.out_rs_full !== 1'b1) begin n_err++; $display("FAIL full_set: got %b want 1", bus.out_rs_full); end
    dispatch(6'h0A, 32'd9, INV, 32'd9, INV);
    @(negedge clk);
    bus.in_rs_enable = 0;
    n_vec++; if (bus.out_rs_full !== 1'b1 || bus.out_CDB_request !== 1'b0) begin
      n_err++; $display("FAIL full_ignore: got full %b req %b want 1 0", bus.out_rs_full, bus.out_CDB_request);
    end
    bus.in_CDB_broadcast = 1; bus.in_CDB_tag = 5'd3; bus.in_CDB_val = 32'd5;
    @(negedge clk);
    bus.in_CDB_broadcast = 0;
    wait_req(20, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL freeze_timeout: no request within budget"); end
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (bus.out_CDB_request !== 1'b1 || bus.out_CDB_tag !== 5'd8 || bus.out_CDB_val !== 32'd5) begin
        n_err++; $display("FAIL freeze_hold: cycle %0d got req %b tag %0d val %h want 1 8 5",
                          i, bus.out_CDB_request, bus.out_CDB_tag, bus.out_CDB_val);
      end
      @(negedge clk);
    end
    for (int k = 0; k < NE; k++) begin
      wait_req(20, ok);
      n_vec++; if (!ok || bus.out_CDB_tag !== 5'(BASE + k) || bus.out_CDB_val !== 32'(5 * (k + 1))) begin
        n_err++; $display("FAIL order_result: idx %0d got req %b tag %0d val %h want 1 %0d %0h",
                          k, ok, bus.out_CDB_tag, bus.out_CDB_val, BASE + k, 5 * (k + 1));
      end
      bus.in_CDB_grant = 1;
      @(negedge clk);
      bus.in_CDB_grant = 0;
      if (k == 0) begin
        n_vec++; if (bus.out_rs_full !== 1'b0 || bus.out_rs_tag !== 5'd8) begin
          n_err++; $display("FAIL first_free: got full %b rs_tag %0d want 0 8", bus.out_rs_full, bus.out_rs_tag);
        end
      end
    end
    bus.in_CDB_grant = 1;
    repeat (6) @(negedge clk);
    bus.in_CDB_grant = 0;
    n_vec++; if (bus.out_CDB_request !== 1'b0 || bus.out_rs_full !== 1'b0 || bus.out_rs_tag !== 5'd8) begin
      n_err++; $display("FAIL drain_idle: got req %b full %b rs_tag %0d want 0 0 8",
                        bus.out_CDB_request, bus.out_rs_full, bus.out_rs_tag);
    end
  endtask

  task automatic test_bypass_and_reset();
    bit ok;
    do_reset();
    dispatch(6'h0A, 32'hBAD, 5'd5, 32'd2, INV);
    bus.in_CDB_broadcast = 1; bus.in_CDB_tag = 5'd5; bus.in_CDB_val = 32'd7;
    @(negedge clk);
    idle_inputs();
    wait_req(20, ok);
    n_vec++; if (!ok || bus.out_CDB_val !== 32'd14) begin
      n_err++; $display("FAIL bypass_capture: got req %b val %h want 1 e", ok, bus.out_CDB_val);
    end
    dispatch(6'h1A, 32'd3, INV, 32'd3, INV);
    @(negedge clk);
    bus.in_rs_enable = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    n_vec++; if (bus.out_CDB_request !== 1'b0 || bus.out_rs_full !== 1'b0 || bus.out_rs_tag !== 5'd8) begin
      n_err++; $display("FAIL midflight_reset: got req %b full %b rs_tag %0d want 0 0 8",
                        bus.out_CDB_request, bus.out_rs_full, bus.out_rs_tag);
    end
    repeat (LAT + 3) @(negedge clk);
    n_vec++; if (bus.out_CDB_request !== 1'b0) begin n_err++; $display("FAIL reset_flush: got req 1 want 0"); end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    bit          mbusy [NE];
    logic [31:0] e_lo [32], e_hi [32];
    logic [3:0]  e_icc [32];
    logic        e_ccv [32];
    bit          ext_pend [8];
    logic [31:0] ext_val [8];
    int          n_busy, free_i, bc, p;
    logic [5:0]  op;
    logic [31:0] a, b;
    bit          done;
    do_reset();
    for (int i = 0; i < NE; i++) mbusy[i] = 0;
    for (int i = 0; i < 8; i++) ext_pend[i] = 0;
    done = 0;
    for (int cyc = 0; cyc < 800 && !done; cyc++) begin
      bit drain;
      drain = (cyc >= 500);
      n_busy = 0; free_i = -1;
      for (int i = NE - 1; i >= 0; i--) begin
        if (mbusy[i]) n_busy++; else free_i = i;
      end
      n_vec++; if (bus.out_rs_full !== (n_busy == NE)) begin
        n_err++; $display("FAIL rnd_full: cycle %0d got %b want %b", cyc, bus.out_rs_full, n_busy == NE);
      end
      if (free_i >= 0) begin
        n_vec++; if (bus.out_rs_tag !== 5'(BASE + free_i)) begin
          n_err++; $display("FAIL rnd_rs_tag: cycle %0d got %0d want %0d", cyc, bus.out_rs_tag, BASE + free_i);
        end
      end
      if (bus.out_CDB_request === 1'b1) begin
        int t;
        t = int'(bus.out_CDB_tag);
        n_vec++;
        if (t < BASE || t >= BASE + NE || !mbusy[t - BASE]) begin
          n_err++; $display("FAIL rnd_tag: cycle %0d got tag %0d not outstanding", cyc, t);
        end else if ({bus.out_CDB_val, bus.out_Y_val, bus.out_ICC_flags, bus.out_ICC_valid} !==
                     {e_lo[t], e_hi[t], e_icc[t], e_ccv[t]}) begin
          n_err++; $display("FAIL rnd_result: tag %0d got %h %h %b %b want %h %h %b %b", t,
                            bus.out_CDB_val, bus.out_Y_val, bus.out_ICC_flags, bus.out_ICC_valid,
                            e_lo[t], e_hi[t], e_icc[t], e_ccv[t]);
        end
      end
      if (drain && n_busy == 0) begin
        done = 1;
        break;
      end
      // External producer broadcast.
      bc = -1;
      if (drain || $urandom_range(0, 1) == 1) begin
        int off;
        off = $urandom_range(0, 7);
        for (int j = 0; j < 8; j++)
          if (bc < 0 && ext_pend[(j + off) % 8]) bc = (j + off) % 8;
      end
      bus.in_CDB_broadcast = (bc >= 0);
      bus.in_CDB_tag = (bc >= 0) ? 5'(bc) : 5'd0;
      bus.in_CDB_val = (bc >= 0) ? ext_val[bc] : $urandom;
      // Dispatch.
      bus.in_rs_enable = 0;
      if (!drain && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 4))
          0: op = 6'h0A; 1: op = 6'h0B; 2: op = 6'h1A; 3: op = 6'h1B;
          default: op = 6'($urandom_range(0, 63));
        endcase
        a = pick_val(); b = pick_val();
        dispatch(op, a, INV, b, INV);
        if (free_i >= 0) begin
          p = -1;
          if ($urandom_range(0, 2) == 0)
            for (int j = 0; j < 8; j++) if (p < 0 && !ext_pend[j] && j != bc) p = j;
          if (p >= 0) begin
            ext_pend[p] = 1; ext_val[p] = b;
            bus.in_tag_2 = 5'(p); bus.in_val_2 = $urandom;
          end
          ref_mul(op, a, b, e_lo[BASE + free_i], e_hi[BASE + free_i], e_icc[BASE + free_i], e_ccv[BASE + free_i]);
          mbusy[free_i] = 1;
        end
      end
      if (bc >= 0) ext_pend[bc] = 0;
      // Grant; a grant with no request must be ignored.
      if (bus.out_CDB_request === 1'b1) begin
        bus.in_CDB_grant = drain || ($urandom_range(0, 3) != 0);
        if (bus.in_CDB_grant && bus.out_CDB_tag >= 5'(BASE) && bus.out_CDB_tag < 5'(BASE + NE))
          mbusy[int'(bus.out_CDB_tag) - BASE] = 0;
      end else begin
        bus.in_CDB_grant = $urandom_range(0, 1);
      end
      @(negedge clk);
    end
    idle_inputs();
    n_vec++; if (!done) begin n_err++; $display("FAIL rnd_drain: station not empty after cycle budget"); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_umul_latency();
    test_cdb_wakeup();
    test_smulcc();
    test_full_and_freeze();
    test_bypass_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
